tinycore_prog_loader: RTL and testbench

Upstream stage of the tinycore accumulator CPU. It owns the 16x8 instruction memory and fills it at run time from a byte-wide, valid/ready load stream. A framed, checksummed protocol replaces hard-coded program contents. It serves the core's instruction fetch through a registered read port and gates core execution (core_run) until a program has loaded and validated.

---
 rtl/tinycore_pkg.sv | 27 ++
 rtl/tinycore_imem.sv | 50 +++++
 rtl/tinycore_prog_loader.sv | 138 +++++++++++++
 tb/tb_tinycore_prog_loader.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinycore_pkg.sv
// Shared definitions for the tinycore CPU and its program loader:
// opcodes, instruction-memory geometry and the loader state encoding.
package tinycore_pkg;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    // Upper nibble of an instruction word; the lower nibble is the operand.
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JZ  = 4'h7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN   = 3'd1,
        ST_DATA  = 3'd2,
        ST_CSUM  = 3'd3,
        ST_RUN   = 3'd4,
        ST_ERROR = 3'd5
    } ld_state_e;

endpackage

// File: rtl/tinycore_imem.sv
// Instruction memory: DEPTH x 8 register file cleared by reset, one write
// port and one registered read port whose data holds when not reading.
module tinycore_imem #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] mem_d [DEPTH];
    logic [7:0] rdata_q, rdata_d;

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem_q[raddr];
        end
    end

    // Reset must clear every word, so this stays a flop array rather than a RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rdata_q <= '0;
        end else begin
            mem_q   <= mem_d;
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/tinycore_prog_loader.sv
// Program loader: receives a LEN/data/CSUM byte frame, fills instruction
// memory, and releases the core (core_run) only after a checksum match.
module tinycore_prog_loader #(
    parameter int DEPTH = tinycore_pkg::DEPTH,
    parameter int AW    = tinycore_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ena,
    input  logic          load_start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_data,
    output logic          ld_ready,
    input  logic          fetch_req,
    input  logic [AW-1:0] fetch_addr,
    output logic [7:0]    fetch_instr,
    output logic          fetch_valid,
    output logic          core_run,
    output logic          load_err,
    output logic [AW:0]   words_loaded
);

    import tinycore_pkg::*;

    ld_state_e   state_q, state_d;
    logic [AW:0] len_q, len_d;
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] words_q, words_d;
    logic [7:0]  acc_q, acc_d;
    logic        fetch_valid_q, fetch_valid_d;

    logic        xfer;
    logic        len_ok;
    logic        mem_we;
    logic        mem_re;
    logic [AW:0] wptr_inc;

    // load_start masks ready so a coincident byte is never consumed.
    always_comb begin
        ld_ready = 1'b0;
        if (ena && !load_start) begin
            ld_ready = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
        end
    end

    assign xfer     = ld_valid & ld_ready;
    assign len_ok   = (ld_data != 8'd0) && (32'(ld_data) <= 32'(DEPTH));
    assign wptr_inc = wptr_q + (AW+1)'(1);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        wptr_d  = wptr_q;
        acc_d   = acc_q;
        words_d = words_q;
        mem_we  = 1'b0;
        if (ena) begin
            if (load_start) begin
                state_d = ST_LEN;
                wptr_d  = '0;
                acc_d   = '0;
            end else if (xfer) begin
                unique case (state_q)
                    ST_LEN: begin
                        if (len_ok) begin
                            len_d   = ld_data[AW:0];
                            wptr_d  = '0;
                            acc_d   = ld_data;
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end
                    ST_DATA: begin
                        mem_we = 1'b1;
                        acc_d  = acc_q ^ ld_data;
                        wptr_d = wptr_inc;
                        if (wptr_inc == len_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (ld_data == acc_q) begin
                            state_d = ST_RUN;
                            words_d = len_q;
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Reads only in RUN, which also rules out any read/write collision.
    assign mem_re        = ena & fetch_req & (state_q == ST_RUN);
    assign fetch_valid_d = mem_re;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            len_q         <= '0;
            wptr_q        <= '0;
            words_q       <= '0;
            acc_q         <= '0;
            fetch_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            len_q         <= len_d;
            wptr_q        <= wptr_d;
            words_q       <= words_d;
            acc_q         <= acc_d;
            fetch_valid_q <= fetch_valid_d;
        end
    end

    tinycore_imem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_imem (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .waddr (wptr_q[AW-1:0]),
        .wdata (ld_data),
        .re    (mem_re),
        .raddr (fetch_addr),
        .rdata (fetch_instr)
    );

    assign fetch_valid  = fetch_valid_q;
    assign core_run     = (state_q == ST_RUN);
    assign load_err     = (state_q == ST_ERROR);
    assign words_loaded = words_q;

endmodule

// File: tb/tb_tinycore_prog_loader.sv
// Randomized self-checking bench for tinycore_prog_loader against a
// frame-level reference model (memory image, run/error flags, length).
module tb_tinycore_prog_loader;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ena = 1'b0;
    logic          load_start = 1'b0;
    logic          ld_valid = 1'b0;
    logic [7:0]    ld_data = 8'h00;
    logic          ld_ready;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;
    logic [7:0]    fetch_instr;
    logic          fetch_valid;
    logic          core_run;
    logic          load_err;
    logic [AW:0]   words_loaded;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]  mem_m [DEPTH];
    logic        run_m;
    logic        err_m;
    logic [AW:0] words_m;
    logic [7:0]  last_instr_m;
    logic [7:0]  fdata [DEPTH];

    tinycore_prog_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ena          (ena),
        .load_start   (load_start),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .fetch_req    (fetch_req),
        .fetch_addr   (fetch_addr),
        .fetch_instr  (fetch_instr),
        .fetch_valid  (fetch_valid),
        .core_run     (core_run),
        .load_err     (load_err),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_model();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 8'h00;
        run_m        = 1'b0;
        err_m        = 1'b0;
        words_m      = '0;
        last_instr_m = 8'h00;
    endtask

    // Only valid in IDLE/RUN/ERROR, where the loader never accepts bytes.
    task automatic check_status(input string tag);
        check_val({tag, ".core_run"}, 32'(core_run), 32'(run_m));
        check_val({tag, ".load_err"}, 32'(load_err), 32'(err_m));
        check_val({tag, ".words_loaded"}, 32'(words_loaded), 32'(words_m));
        check_val({tag, ".ld_ready"}, 32'(ld_ready), 32'd0);
        $display("status %s: run=%0b err=%0b words=%0d", tag, core_run, load_err, words_loaded);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit done;
        int guard;
        done  = 1'b0;
        guard = 0;
        ld_data = b;
        while (!done) begin
            ld_valid = ($urandom_range(0, 2) != 0);
            #1;
            check_val("ld_ready_loading", 32'(ld_ready), 32'd1);
            done = ld_valid && ld_ready;
            step();
            guard++;
            if (!done && guard > 40) begin
                check_val("ld_xfer_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
        end
        ld_valid = 1'b0;
        $display("byte %02h transferred after %0d cycles", b, guard);
    endtask

    task automatic ena_pause(input int cycles);
        ena = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            ld_valid   = 1'($urandom_range(0, 1));
            load_start = 1'($urandom_range(0, 1));
            fetch_req  = 1'($urandom_range(0, 1));
            #1;
            check_val("ld_ready_ena0", 32'(ld_ready), 32'd0);
            step();
            check_val("fetch_valid_ena0", 32'(fetch_valid), 32'd0);
        end
        ld_valid   = 1'b0;
        load_start = 1'b0;
        fetch_req  = 1'b0;
        ena        = 1'b1;
        $display("ena held low for %0d cycles", cycles);
    endtask

    task automatic start_load(input bit with_byte);
        load_start = 1'b1;
        ld_valid   = with_byte;
        ld_data    = 8'h02;
        #1;
        check_val("ld_ready_on_start", 32'(ld_ready), 32'd0);
        step();
        load_start = 1'b0;
        ld_valid   = 1'b0;
        run_m      = 1'b0;
        err_m      = 1'b0;
        #1;
        check_val("core_run_after_start", 32'(core_run), 32'd0);
        check_val("load_err_after_start", 32'(load_err), 32'd0);
        check_val("ld_ready_in_len", 32'(ld_ready), 32'd1);
        $display("load_start issued (coincident byte=%0b)", with_byte);
    endtask

    // Model: a legal length writes words 0..N-1; success needs CSUM == XOR of LEN and data.
    task automatic send_frame(input logic [7:0] len_b, input logic [7:0] csum_b, input int drop_at);
        logic [7:0] x;
        send_byte(len_b);
        if (len_b == 8'd0 || int'(len_b) > DEPTH) begin
            err_m = 1'b1;
        end else begin
            x = len_b;
            for (int i = 0; i < int'(len_b); i++) begin
                if (i == drop_at) ena_pause(5);
                send_byte(fdata[i]);
                mem_m[i] = fdata[i];
                x = x ^ fdata[i];
            end
            send_byte(csum_b);
            if (csum_b == x) begin
                run_m   = 1'b1;
                words_m = len_b[AW:0];
            end else begin
                err_m = 1'b1;
            end
        end
        #1;
        check_status($sformatf("frame_len%0d", len_b));
    endtask

    task automatic fetch_dump();
        for (int a = 0; a < DEPTH; a++) begin
            fetch_req  = 1'b1;
            fetch_addr = AW'(a);
            step();
            fetch_req = 1'b0;
            #1;
            check_val("fetch_valid", 32'(fetch_valid), 32'(run_m));
            if (run_m) begin
                check_val($sformatf("fetch_instr[%0d]", a), 32'(fetch_instr), 32'(mem_m[a]));
                last_instr_m = mem_m[a];
            end else begin
                check_val("fetch_instr_hold", 32'(fetch_instr), 32'(last_instr_m));
            end
            step();
            check_val("fetch_valid_norq", 32'(fetch_valid), 32'd0);
            $display("fetch addr %0d: instr=%02h valid_seen=%0b", a, fetch_instr, run_m);
        end
    endtask

    task automatic fill_random(input int n, output logic [7:0] good_csum);
        logic [7:0] x;
        x = 8'(n);
        for (int i = 0; i < DEPTH; i++) fdata[i] = 8'($urandom);
        for (int i = 0; i < n && i < DEPTH; i++) x = x ^ fdata[i];
        good_csum = x;
    endtask

    initial begin
        logic [7:0] cs;
        reset_model();

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        check_status("reset");
        check_val("reset.fetch_valid", 32'(fetch_valid), 32'd0);
        check_val("reset.fetch_instr", 32'(fetch_instr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ena   = 1'b1;
        step();
        #1;
        check_status("idle");

        // Known good frame 03 41 02 21 61
        start_load(1'b0);
        fdata[0] = 8'h41; fdata[1] = 8'h02; fdata[2] = 8'h21;
        send_frame(8'h03, 8'h61, -1);
        fetch_dump();

        // Same frame with a bad checksum
        start_load(1'b0);
        send_frame(8'h03, 8'h60, -1);
        fetch_dump();

        // Recovery with a random good frame
        start_load(1'b0);
        fill_random(5, cs);
        send_frame(8'h05, cs, -1);
        fetch_dump();

        // Illegal lengths leave memory untouched
        start_load(1'b0);
        send_frame(8'h00, 8'h00, -1);
        start_load(1'b0);
        send_frame(8'h11, 8'h00, -1);
        fetch_dump();
        start_load(1'b0);
        fill_random(1, cs);
        send_frame(8'h01, cs, -1);
        fetch_dump();

        // Randomized frames with backpressure, ena drops and corrupt checksums
        for (int k = 0; k < 24; k++) begin
            int r;
            int n;
            int drop;
            logic [7:0] lb;
            r = int'($urandom_range(0, 9));
            if (r == 0) lb = 8'd0;
            else if (r == 1) lb = 8'($urandom_range(17, 255));
            else lb = 8'($urandom_range(1, DEPTH));
            n = (int'(lb) >= 1 && int'(lb) <= DEPTH) ? int'(lb) : 0;
            fill_random(n, cs);
            if ($urandom_range(0, 3) == 0) cs = cs ^ 8'($urandom_range(1, 255));
            drop = (n > 0 && $urandom_range(0, 1) == 1) ? int'($urandom_range(0, n - 1)) : -1;
            start_load(1'($urandom_range(0, 1)));
            send_frame(lb, cs, drop);
            fetch_dump();
        end

        // Restart from RUN
        start_load(1'b0);
        fill_random(4, cs);
        send_frame(8'h04, cs, -1);
        start_load(1'b0);

        // load_start coincident with a data byte: byte dropped, next byte is LEN
        fill_random(4, cs);
        send_byte(8'h04);
        send_byte(fdata[0]); mem_m[0] = fdata[0];
        send_byte(fdata[1]); mem_m[1] = fdata[1];
        start_load(1'b1);
        fill_random(2, cs);
        send_frame(8'h02, cs, -1);
        fetch_dump();

        // Reset in the middle of DATA
        start_load(1'b0);
        fill_random(4, cs);
        send_byte(8'h04);
        send_byte(fdata[0]);
        send_byte(fdata[1]);
        rst_n = 1'b0;
        reset_model();
        #1;
        check_status("mid_reset");
        check_val("mid_reset.fetch_valid", 32'(fetch_valid), 32'd0);
        check_val("mid_reset.fetch_instr", 32'(fetch_instr), 32'd0);
        step();
        rst_n = 1'b1;
        step();
        #1;
        check_status("after_reset");
        start_load(1'b0);
        fill_random(1, cs);
        send_frame(8'h01, cs, -1);
        fetch_dump();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
